uart_cmd_deframer: RTL and testbench

Consumes the byte stream produced by uart_rx (i_Rx_DV / i_Rx_Byte) and extracts framed host commands.
- Frame format: SOF, CMD, LEN, LEN payload bytes, CHK.
- Payload is buffered internally. After the checksum passes, the frame is delivered downstream as a command header plus a ready/valid payload stream.
- Malformed, truncated or stalled frames are dropped and reported on an error pulse.

---
 rtl/uart_cmd_deframer_if.sv | 33 +++
 rtl/uart_cmd_deframer.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_deframer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_deframer_if.sv
// Delivery-side bundle of uart_cmd_deframer: command header
// plus ready/valid payload stream.
interface uart_cmd_deframer_if #(
  parameter int LW = 6
);
  logic          o_Frame_Valid;
  logic [7:0]    o_Cmd;
  logic [LW-1:0] o_Len;
  logic          o_Data_Valid;
  logic [7:0]    o_Data;
  logic          o_Data_Last;
  logic          i_Data_Ready;

  modport master (
    output o_Frame_Valid,
    output o_Cmd,
    output o_Len,
    output o_Data_Valid,
    output o_Data,
    output o_Data_Last,
    input  i_Data_Ready
  );

  modport slave (
    input  o_Frame_Valid,
    input  o_Cmd,
    input  o_Len,
    input  o_Data_Valid,
    input  o_Data,
    input  o_Data_Last,
    output i_Data_Ready
  );
endinterface

// File: rtl/uart_cmd_deframer.sv
// Extracts SOF/CMD/LEN/payload/CHK frames from the uart_rx byte stream.
// Optional byte stuffing via `define DEFRAMER_ESC_EN.
module uart_cmd_deframer #(
  parameter int         MAX_PAYLOAD  = 32,
  parameter logic [7:0] SOF_BYTE     = 8'h7E,
  parameter int         TIMEOUT_CLKS = 3480
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  uart_cmd_deframer_if.master dlv,
  output logic       o_Err,
  output logic [1:0] o_Err_Code
);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [8:0]    MAX_LEN  = 9'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [1:0] E_OVR = 2'd0;
  localparam logic [1:0] E_LEN = 2'd1;
  localparam logic [1:0] E_CHK = 2'd2;
  localparam logic [1:0] E_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK, S_DLV
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, acc_q;
  logic [LW-1:0] len_q, wr_idx_q, rd_idx_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    mem [MAX_PAYLOAD];
  logic          err_d;
  logic [1:0]    code_d;
  logic          in_frame, data_dv, tmo_clr, sof_abort;
  logic [7:0]    byte_in, chk_sum;
  logic          too_long, len_zero, last, dv_out, beat;

  assign in_frame = state_q inside {S_CMD, S_LEN, S_PAY, S_CHK};

`ifdef DEFRAMER_ESC_EN
  logic esc_q, is_esc;
  assign is_esc    = i_Rx_DV && in_frame && !esc_q
                  && (i_Rx_Byte == 8'h7D);
  assign sof_abort = i_Rx_DV && in_frame && !esc_q
                  && (i_Rx_Byte == SOF_BYTE);
  assign data_dv   = i_Rx_DV && !is_esc && !sof_abort;
  // the escape byte alone must not refresh the inter-byte timer
  assign tmo_clr   = i_Rx_DV && !is_esc;
  assign byte_in   = (esc_q && in_frame) ? (i_Rx_Byte ^ 8'h20)
                                         : i_Rx_Byte;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n)      esc_q <= 1'b0;
    else if (!in_frame) esc_q <= 1'b0;
    else if (i_Rx_DV)  esc_q <= is_esc;
  end
`else
  assign sof_abort = 1'b0;
  assign data_dv   = i_Rx_DV;
  assign tmo_clr   = i_Rx_DV;
  assign byte_in   = i_Rx_Byte;
`endif

  assign chk_sum  = acc_q + byte_in;
  assign too_long = {1'b0, byte_in} > MAX_LEN;
  assign len_zero = (len_q == '0);
  assign last     = (rd_idx_q == len_q - 1'b1);
  assign dv_out   = (state_q == S_DLV) && !len_zero;
  assign beat     = dv_out && dlv.i_Data_Ready;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = E_OVR;
    unique case (state_q)
      S_IDLE:
        if (data_dv && byte_in == SOF_BYTE) state_d = S_CMD;
      S_CMD:
        if (data_dv) state_d = S_LEN;
      S_LEN:
        if (data_dv) begin
          if (too_long) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = E_LEN;
          end else if (byte_in == 8'h00) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
      S_PAY:
        if (data_dv && wr_idx_q == len_q - 1'b1) state_d = S_CHK;
      S_CHK:
        if (data_dv) begin
          if (chk_sum == 8'h00) begin
            state_d = S_DLV;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = E_CHK;
          end
        end
      S_DLV: begin
        if (i_Rx_DV) begin
          err_d  = 1'b1;
          code_d = E_OVR;
        end
        if (dlv.i_Data_Ready && (len_zero || last))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sof_abort) state_d = S_CMD;
    if (in_frame && !tmo_clr && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = E_TMO;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Err      <= 1'b0;
      o_Err_Code <= 2'd0;
      tmo_q      <= '0;
      cmd_q      <= '0;
      acc_q      <= '0;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
    end else begin
      o_Err      <= err_d;
      o_Err_Code <= code_d;
      if (!in_frame || tmo_clr) tmo_q <= '0;
      else                      tmo_q <= tmo_q + 1'b1;
      unique case (state_q)
        S_CMD:
          if (data_dv) begin
            cmd_q <= byte_in;
            acc_q <= byte_in;
          end
        S_LEN:
          if (data_dv && !too_long) begin
            len_q    <= byte_in[LW-1:0];
            acc_q    <= chk_sum;
            wr_idx_q <= '0;
          end
        S_PAY:
          if (data_dv) begin
            acc_q    <= chk_sum;
            wr_idx_q <= wr_idx_q + 1'b1;
          end
        S_CHK: rd_idx_q <= '0;
        S_DLV: if (beat) rd_idx_q <= rd_idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (state_q == S_PAY && data_dv)
      mem[wr_idx_q[IW-1:0]] <= byte_in;
  end

  assign dlv.o_Frame_Valid = (state_q == S_DLV);
  assign dlv.o_Cmd         = cmd_q;
  assign dlv.o_Len         = len_q;
  assign dlv.o_Data_Valid  = dv_out;
  assign dlv.o_Data        = dv_out ? mem[rd_idx_q[IW-1:0]] : 8'h00;
  assign dlv.o_Data_Last   = dv_out && last;
endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Scoreboard bench for uart_cmd_deframer: expected beats/errors are
// queued as frames are driven and popped as the DUT produces them.
module tb_uart_cmd_deframer;
  localparam int MAXP = 32;
  localparam int TMO  = 3480;
  localparam int LW   = $clog2(MAXP + 1);
  localparam int GAP  = 20;
  localparam logic [7:0] SOF = 8'h7E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rdy = 1'b1;
  logic       err;
  logic [1:0] code;
  bit         rnd_rdy = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] dq[$];
  logic [2:0]  eq[$];
  logic [7:0]  pl[$];
  logic [7:0]  fq[$];

  uart_cmd_deframer_if #(.LW(LW)) dif ();
  assign dif.i_Data_Ready = rdy;

  uart_cmd_deframer #(
    .MAX_PAYLOAD (MAXP),
    .SOF_BYTE    (SOF),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock   (clk),
    .i_Rst_n   (rst_n),
    .i_Rx_DV   (rx_dv),
    .i_Rx_Byte (rx_byte),
    .dlv       (dif.master),
    .o_Err     (err),
    .o_Err_Code(code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit e,
      input logic [7:0] c, input int len,
      input logic [7:0] d, input bit l);
    return {6'b0, e, c, 8'(len), d, l};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) begin
        logic [2:0] x;
        x = eq.size() > 0 ? eq.pop_front() : 3'd4;
        check("err_code", {29'b0, 1'b0, code}, {29'b0, x});
      end
      if (dif.o_Frame_Valid && rdy) begin
        logic [31:0] x, g;
        if (dif.o_Data_Valid)
          g = mk(0, dif.o_Cmd, int'(dif.o_Len),
                 dif.o_Data, dif.o_Data_Last);
        else
          g = mk(1, dif.o_Cmd, int'(dif.o_Len), 8'h00, 1'b0);
        x = dq.size() > 0 ? dq.pop_front() : 32'hFFFF_FFFF;
        check("beat", g, x);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_q();
    foreach (fq[i]) begin
      if (i > 0) repeat (GAP) @(posedge clk);
      send_byte(fq[i]);
    end
  endtask

  task automatic push_data(input logic [7:0] b);
`ifdef DEFRAMER_ESC_EN
    if (b == 8'h7D || b == 8'h7E) begin
      fq.push_back(8'h7D);
      fq.push_back(b ^ 8'h20);
    end else fq.push_back(b);
`else
    fq.push_back(b);
`endif
  endtask

  task automatic push_frame(input logic [7:0] c);
    if (pl.size() == 0) dq.push_back(mk(1, c, 0, 8'h00, 1'b0));
    else foreach (pl[i])
      dq.push_back(mk(0, c, pl.size(), pl[i], i == pl.size() - 1));
  endtask

  task automatic build_frame(input logic [7:0] c, input bit bad);
    logic [7:0] s;
    s = c + 8'(pl.size());
    fq.delete();
    fq.push_back(SOF);
    push_data(c);
    fq.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      push_data(pl[i]);
      s = s + pl[i];
    end
    s = 8'h00 - s;
    if (bad) s = s ^ 8'h5A;
    push_data(s);
    if (bad) eq.push_back(3'd2);
    else     push_frame(c);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (!dif.o_Frame_Valid) break;
      @(posedge clk);
      #1;
    end
    check("dlv_done", {31'b0, dif.o_Frame_Valid}, 32'd0);
    repeat (GAP) @(posedge clk);
  endtask

  task automatic rand_frame(input int len, input bit bad);
    pl.delete();
    for (int i = 0; i < len; i++)
      pl.push_back(8'($urandom_range(0, 255)));
    build_frame(8'($urandom_range(0, 255)), bad);
    send_q();
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fv"}, {31'b0, dif.o_Frame_Valid}, 32'd0);
    check({tag, "_dv"}, {31'b0, dif.o_Data_Valid}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_cmd"}, {24'b0, dif.o_Cmd}, 32'd0);
    check({tag, "_len"}, {26'b0, dif.o_Len}, 32'd0);
    check({tag, "_data"}, {24'b0, dif.o_Data}, 32'd0);
  endtask

  initial begin
    int n;
    #23;
    check_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_zero("idle");

    // good frame from the reference byte sequence
    pl = '{8'hAA, 8'hBB, 8'hCC};
    push_frame(8'h01);
    fq = '{SOF, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
    send_q();
    check("fv_rise", {31'b0, dif.o_Frame_Valid}, 32'd1);
    check("hdr_cmd", {24'b0, dif.o_Cmd}, 32'h01);
    check("hdr_len", {26'b0, dif.o_Len}, 32'd3);
    wait_idle();

    // bad checksum, then a good frame
    eq.push_back(3'd2);
    fq = '{SOF, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    send_q();
    check("chk_nofv", {31'b0, dif.o_Frame_Valid}, 32'd0);
    repeat (GAP) @(posedge clk);
    rand_frame(5, 0);

    // bad length; trailing bytes ignored
    eq.push_back(3'd1);
    fq = '{SOF, 8'h05, 8'h21};
    send_q();
    check("len_err", {30'b0, err, 1'b0}, {30'b0, 1'b1, 1'b0});
    fq = '{8'h01, 8'hAA, 8'h03, 8'h00};
    repeat (GAP) @(posedge clk);
    send_q();
    repeat (GAP) @(posedge clk);

    // timeout latency
    eq.push_back(3'd3);
    fq = '{SOF, 8'h05};
    send_q();
    n = 0;
    for (int i = 1; i <= TMO + 20; i++) begin
      @(posedge clk);
      #1;
      if (err) begin
        n = i;
        break;
      end
    end
    check("tmo_lat", n, TMO);
    repeat (GAP) @(posedge clk);
    rand_frame(2, 0);

    // zero-length frame under backpressure with overrun
    rdy = 1'b0;
    pl.delete();
    push_frame(8'h42);
    fq = '{SOF, 8'h42, 8'h00, 8'hBE};
    send_q();
    check("z_fv", {31'b0, dif.o_Frame_Valid}, 32'd1);
    check("z_len", {26'b0, dif.o_Len}, 32'd0);
    repeat (3) @(posedge clk);
    eq.push_back(3'd0);
    send_byte(8'h55);
    repeat (5) @(posedge clk);
    #1;
    check("z_hold", {31'b0, dif.o_Frame_Valid}, 32'd1);
    check("z_cmd", {24'b0, dif.o_Cmd}, 32'h42);
    check("z_nodv", {31'b0, dif.o_Data_Valid}, 32'd0);
    @(posedge clk);
    #1;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("z_exit", {31'b0, dif.o_Frame_Valid}, 32'd0);
    repeat (GAP) @(posedge clk);

    // random backpressure, including max length and a bad checksum
    rnd_rdy = 1'b1;
    rand_frame(MAXP, 0);
    rand_frame(1, 0);
    rand_frame(7, 1);
    rand_frame($urandom_range(1, MAXP), 0);
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    repeat (GAP) @(posedge clk);

    // reset in the middle of a payload
    fq = '{SOF, 8'h09, 8'h04, 8'h11, 8'h22};
    send_q();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (GAP) @(posedge clk);
    rand_frame(4, 0);

`ifdef DEFRAMER_ESC_EN
    pl = '{8'h7E};
    push_frame(8'h01);
    fq = '{SOF, 8'h01, 8'h01, 8'h7D, 8'h5E, 8'h80};
    send_q();
    wait_idle();
    pl.delete();
    push_frame(8'h05);
    fq = '{SOF, 8'h33, SOF, 8'h05, 8'h00, 8'hFB};
    send_q();
    wait_idle();
`else
    pl = '{8'h7E, 8'h7D};
    build_frame(8'h10, 0);
    send_q();
    wait_idle();
`endif

    repeat (GAP) @(posedge clk);
    check("dq_left", dq.size(), 0);
    check("eq_left", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
